// File: rtl/global_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : global_out_buffer
// Description : Byte FIFO with registered head and valid/ready drain, between
//               the global-output write path and an external consumer.
//               Defining GLOBAL_OUT_DROP_CNT_EN adds a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module global_out_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [7:0]        data_in,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef GLOBAL_OUT_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q;
    logic [7:0]        out_data_q, out_data_d;
    logic              full_q;
    logic              overflow_q;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W-1:0] w_rp_inc;

    assign w_pop    = out_valid_q & out_ready;
    assign w_push   = write & (~full_q | w_pop);
    assign w_drop   = write & full_q & ~w_pop;
    assign w_rp_inc = rp_q + C_PTR_ONE;

    always_comb begin
        wp_d       = w_push ? (wp_q + C_PTR_ONE) : wp_q;
        rp_d       = w_pop  ? w_rp_inc : rp_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        // The next head comes from data_in whenever the buffer is empty once
        // the pop is accounted for, since the array write lands on this edge.
        if (w_pop) begin
            if (count_q > C_CNT_ONE) begin
                out_data_d = mem_q[w_rp_inc];
            end else if (w_push) begin
                out_data_d = data_in;
            end
        end else if ((count_q == '0) && w_push) begin
            out_data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wp_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
            out_data_q  <= out_data_d;
            full_q      <= (count_d == C_DEPTH);
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef GLOBAL_OUT_DROP_CNT_EN
    logic [7:0] drop_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_q <= 8'h00;
        end else if (w_drop && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_global_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_global_out_buffer
// Description : Scoreboard bench for global_out_buffer (drop counter checked
//               when GLOBAL_OUT_DROP_CNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_global_out_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              write;
    logic [7:0]        data_in;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
`ifdef GLOBAL_OUT_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    global_out_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .full       (full),
        .count      (count),
        .overflow   (overflow)
`ifdef GLOBAL_OUT_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       m_overflow = 1'b0;
    int         m_drop     = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: called at a falling edge, checks the head, updates the
    // model for the coming rising edge, then checks registered state.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy);
        logic       pop;
        logic [7:0] head;
        write     = wr;
        data_in   = wr ? d : 8'hxx;
        out_ready = rdy;
        chk_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        pop = (exp_q.size() > 0) && rdy;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk_eq(pop ? "pop_data" : "held_data", {24'd0, out_data}, {24'd0, head});
        end
        if (pop) void'(exp_q.pop_front());
        if (wr) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(d);
            end else begin
                m_overflow = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk_eq("count", {28'd0, count}, exp_q.size());
        chk_eq("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
        chk_eq("overflow", {31'd0, overflow}, {31'd0, m_overflow});
`ifdef GLOBAL_OUT_DROP_CNT_EN
        chk_eq("drop_count", {24'd0, drop_count}, m_drop);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (exp_q.size() == 0) break;
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk_eq("drained", {28'd0, count}, 0);
    endtask

    initial begin
        reset     = 1'b0;
        write     = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        #12;
        chk_eq("rst_valid", {31'd0, out_valid}, 0);
        chk_eq("rst_data", {24'd0, out_data}, 0);
        chk_eq("rst_count", {28'd0, count}, 0);
        chk_eq("rst_full", {31'd0, full}, 0);
        chk_eq("rst_overflow", {31'd0, overflow}, 0);
`ifdef GLOBAL_OUT_DROP_CNT_EN
        chk_eq("rst_drop", {24'd0, drop_count}, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Single byte into empty buffer, then hold it before popping.
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        drain();

        // Fill, drop one, then push+pop while full.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h09, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        drain();

        // Continuous streaming: pointers wrap repeatedly without bubbles.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        drain();

        // Asynchronous reset with buffered bytes and overflow set.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_eq("arst_valid", {31'd0, out_valid}, 0);
        chk_eq("arst_count", {28'd0, count}, 0);
        chk_eq("arst_overflow", {31'd0, overflow}, 0);
        exp_q.delete();
        m_overflow = 1'b0;
        m_drop     = 0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h11, 1'b0);
        chk_eq("post_rst_head", {24'd0, out_data}, 32'h11);
        drain();

        // Saturating drop counter.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'hEE, 1'b0);
`ifdef GLOBAL_OUT_DROP_CNT_EN
        chk_eq("drop_sat", {24'd0, drop_count}, 32'hFF);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
